seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter BIN_W, default 16: width of the binary input, legal range 4..27.
REQ-003 Parameter SCAN_DIV, default 50000: clock cycles each digit stays enabled, minimum 2.
REQ-004 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, minimum 2.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 bin_in  in  BIN_W  binary value to display.
REQ-008 load  in  1  request to capture bin_in and mode_sel.
REQ-009 mode_sel  in  1  0 = hexadecimal display, 1 = decimal display.
REQ-010 disp_end  in  1  level: show blinking "End" in place of the value.
REQ-011 seg_n  out  7  active-low segments {g,f,e,d,c,b,a}; seg_n[0] = a.
REQ-012 dig_en_n  out  NUM_DIGITS  active-low one-hot digit enable; bit 0 = rightmost digit.
REQ-013 busy  out  1  decimal conversion in progress.
REQ-014 ovf  out  1  last captured decimal value does not fit in NUM_DIGITS digits.

Function
REQ-015 Encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, n=0101011, dash=0111111, blank=1111111.
REQ-016 Capture SHALL occur on any edge where load=1 and busy=0; load while busy=1 SHALL be ignored and not queued.
REQ-017 Hex capture SHALL write nibble i of bin_in (zero-extended to 4*NUM_DIGITS bits; bits beyond are dropped) to digit i at that edge; busy SHALL stay 0 and ovf SHALL be cleared.
REQ-018 Decimal capture SHALL start an iterative shift-add-3 conversion: busy=1 for exactly BIN_W cycles after the accepting edge, then the digit register updates on the edge busy falls.
REQ-019 Until a conversion completes, the previously displayed value SHALL remain on the display unchanged.
REQ-020 If the decimal value >= 10^NUM_DIGITS, completion SHALL set ovf=1 and load dash into every digit; otherwise ovf=0 and BCD digits load, leading zeros shown as 0.
REQ-021 A scan counter SHALL count 0..SCAN_DIV-1; on wrap the digit index advances 0,1,..,NUM_DIGITS-1,0; each digit is enabled for exactly SCAN_DIV cycles.
REQ-022 dig_en_n SHALL be ~(1 << index) and seg_n SHALL be the registered encoding of digit[index], both changing on the same edge.
REQ-023 While disp_end=1: digit2=E, digit1=n, digit0=d, higher digits blank; a blink counter toggles phase every BLINK_DIV cycles; phase off forces seg_n=1111111; dig_en_n keeps scanning.
REQ-024 On the first cycle disp_end is sampled 1, blink phase SHALL be on and the blink counter at 0; while disp_end=0 the counter is held at 0.
REQ-025 disp_end SHALL not affect capture, conversion, busy or ovf; on deassertion the stored value reappears on the next scan update.

Reset
REQ-026 reset=1 SHALL force: all digits 0, index 0, scan and blink counters 0, busy=0, ovf=0, dig_en_n=~1, seg_n=1000000.
REQ-027 reset SHALL abort a conversion in progress with no partial result displayed, and SHALL override load on the same edge.

Verification (NUM_DIGITS=4, BIN_W=16, SCAN_DIV=4, BLINK_DIV=8)
REQ-028 Hex: load 0x1A2F, mode_sel=0 -> busy never 1; digit0 shows 0001110, digit1 0100100, digit2 0001000, digit3 1111001; each enable low 4 cycles.
REQ-029 Decimal: load 1234, mode_sel=1 -> busy high exactly 16 cycles; old value held meanwhile; then digits 4,3,2,1 (digit0 = 0011001), ovf=0.
REQ-030 Overflow: decimal load 10000 -> after 16 busy cycles ovf=1, all four digits 0111111; then hex load 0x0005 -> ovf=0, display 0005.
REQ-031 Busy collision: decimal load 42 then load 0xFFFF on the busy cycle after -> second load ignored, result 0042.
REQ-032 End: disp_end=1 -> digit2 0000110, digit1 0101011, digit0 0100001, digit3 blank; 8 cycles on, 8 all-blank, repeating; deassert -> stored value returns.
REQ-033 Reset mid-conversion: reset on 5th busy cycle of decimal load 999 -> busy=0, ovf=0, display 0000, dig_en_n=1110 next cycle.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Multiplexed seven-segment display driver. Captures a binary value and shows
//   it in hex (immediately) or decimal (after an iterative shift-add-3
//   conversion), scans the digits one at a time, and can replace the value
//   with a blinking "End" message.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : synchronous, active-high
//   bin_in    : binary value to display
//   load      : capture bin_in/mode_sel when not busy
//   mode_sel  : 0 = hex, 1 = decimal
//   disp_end  : level, show blinking "End"
//   seg_n     : active-low segments {g,f,e,d,c,b,a}
//   dig_en_n  : active-low one-hot digit enable, bit 0 = rightmost digit
//   busy      : decimal conversion in progress
//   ovf       : last decimal value did not fit in NUM_DIGITS digits
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 16,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    input  logic                  mode_sel,
    input  logic                  disp_end,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  busy,
    output logic                  ovf
);

    // BCD digits needed to hold any BIN_W-bit value (floor(W*log10 2)+1,
    // exact for W <= 33); the conversion register is at least NUM_DIGITS wide
    // so digits above NUM_DIGITS flag overflow.
    localparam int BCD_D  = (BIN_W * 3) / 10 + 1;
    localparam int DD     = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
    localparam int HEX_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int SC_W   = $clog2(SCAN_DIV);
    localparam int BL_W   = $clog2(BLINK_DIV);
    localparam int STEP_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    // Digit symbols: 0..15 are hex values, then the special glyphs.
    localparam logic [4:0] SYM_D     = 5'd13;
    localparam logic [4:0] SYM_E     = 5'd14;
    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_N     = 5'd17;
    localparam logic [4:0] SYM_BLANK = 5'd18;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    function automatic logic [6:0] enc(input logic [4:0] s);
        logic [6:0] r;
        case (s)
            5'd0:    r = 7'b1000000;
            5'd1:    r = 7'b1111001;
            5'd2:    r = 7'b0100100;
            5'd3:    r = 7'b0110000;
            5'd4:    r = 7'b0011001;
            5'd5:    r = 7'b0010010;
            5'd6:    r = 7'b0000010;
            5'd7:    r = 7'b1111000;
            5'd8:    r = 7'b0000000;
            5'd9:    r = 7'b0010000;
            5'd10:   r = 7'b0001000;
            5'd11:   r = 7'b0000011;
            5'd12:   r = 7'b1000110;
            5'd13:   r = 7'b0100001;
            5'd14:   r = 7'b0000110;
            5'd15:   r = 7'b0001110;
            5'd16:   r = 7'b0111111;
            5'd17:   r = 7'b0101011;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    state_t                       state, state_nxt;
    logic [STEP_W-1:0]            step_cnt, step_nxt;
    logic [BIN_W-1:0]             sh, sh_nxt;
    logic [4*DD-1:0]              bcd, bcd_nxt, bcd_adj, bcd_step;
    logic                         conv_ovf;
    logic [NUM_DIGITS-1:0][4:0]   digits, digits_nxt;
    logic                         ovf_nxt;
    logic [HEX_W-1:0]             hex_val;

    logic [SC_W-1:0]              scan_cnt, scan_nxt;
    logic [IDX_W-1:0]             idx, idx_nxt;
    logic [BL_W-1:0]              blink_cnt, blink_nxt;
    logic                         blink_on, blink_on_nxt;
    logic [4:0]                   sym;
    logic [6:0]                   seg_nxt;
    logic [NUM_DIGITS-1:0]        en_nxt;

    assign busy    = (state == S_CONV);
    assign hex_val = HEX_W'(bin_in);

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
    // the next binary bit in at the bottom.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DD; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[4*DD-2:0], sh[BIN_W-1]};
        conv_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < DD; i++) begin
            if (bcd_step[4*i +: 4] != 4'd0)
                conv_ovf = 1'b1;
        end
    end

    // Capture / conversion FSM next-state.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step_cnt;
        sh_nxt     = sh;
        bcd_nxt    = bcd;
        digits_nxt = digits;
        ovf_nxt    = ovf;
        case (state)
            S_IDLE: begin
                if (load) begin
                    if (mode_sel) begin
                        state_nxt = S_CONV;
                        step_nxt  = '0;
                        sh_nxt    = bin_in;
                        bcd_nxt   = '0;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++)
                            digits_nxt[i] = {1'b0, hex_val[4*i +: 4]};
                        ovf_nxt = 1'b0;
                    end
                end
            end
            S_CONV: begin
                bcd_nxt  = bcd_step;
                sh_nxt   = sh << 1;
                step_nxt = step_cnt + 1'b1;
                // Last bit: the display only changes here, so a conversion
                // never shows a partial result.
                if (step_cnt == STEP_W'(BIN_W - 1)) begin
                    state_nxt = S_IDLE;
                    ovf_nxt   = conv_ovf;
                    for (int i = 0; i < NUM_DIGITS; i++)
                        digits_nxt[i] = conv_ovf ? SYM_DASH : {1'b0, bcd_step[4*i +: 4]};
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Scan, blink and output next-state. Outputs are registered from the
    // post-edge index and digit contents so enable and segments move together;
    // blanking uses the phase of the cycle being sampled.
    always_comb begin
        scan_nxt = scan_cnt + 1'b1;
        idx_nxt  = idx;
        if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
            scan_nxt = '0;
            idx_nxt  = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end

        blink_nxt    = blink_cnt;
        blink_on_nxt = blink_on;
        if (!disp_end) begin
            blink_nxt    = '0;
            blink_on_nxt = 1'b1;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_nxt    = '0;
            blink_on_nxt = ~blink_on;
        end else begin
            blink_nxt = blink_cnt + 1'b1;
        end

        if (disp_end) begin
            case (int'(idx_nxt))
                0:       sym = SYM_D;
                1:       sym = SYM_N;
                2:       sym = SYM_E;
                default: sym = SYM_BLANK;
            endcase
        end else begin
            sym = digits_nxt[idx_nxt];
        end

        seg_nxt = (disp_end && !blink_on) ? 7'b1111111 : enc(sym);
        en_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            step_cnt  <= '0;
            sh        <= '0;
            bcd       <= '0;
            digits    <= '0;
            ovf       <= 1'b0;
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            seg_n     <= 7'b1000000;
            dig_en_n  <= ~NUM_DIGITS'(1);
        end else begin
            state     <= state_nxt;
            step_cnt  <= step_nxt;
            sh        <= sh_nxt;
            bcd       <= bcd_nxt;
            digits    <= digits_nxt;
            ovf       <= ovf_nxt;
            scan_cnt  <= scan_nxt;
            idx       <= idx_nxt;
            blink_cnt <= blink_nxt;
            blink_on  <= blink_on_nxt;
            seg_n     <= seg_nxt;
            dig_en_n  <= en_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
//   Directed and randomized stimulus for seven_seg_scan_driver with
//   NUM_DIGITS=4, BIN_W=16, SCAN_DIV=4, BLINK_DIV=8. A cycle-level behavioural
//   model (decimal arithmetic, elapsed-cycle scan/blink positions) predicts
//   every output on every cycle.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int BW = 16;
    localparam int SD = 4;
    localparam int BD = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] bin_in = '0;
    logic          load = 1'b0;
    logic          mode_sel = 1'b0;
    logic          disp_end = 1'b0;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_en_n;
    logic          busy;
    logic          ovf;

    int tests = 0;
    int fails = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLINK_DIV(BD)
    ) dut (
        .clock(clock), .reset(reset), .bin_in(bin_in), .load(load),
        .mode_sel(mode_sel), .disp_end(disp_end), .seg_n(seg_n),
        .dig_en_n(dig_en_n), .busy(busy), .ovf(ovf)
    );

    always #5 clock = ~clock;

    // Glyph table: 0..15 hex, 16 dash, 17 n, 18 blank.
    function automatic logic [6:0] enc_of(input int s);
        case (s)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
           12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
           15: return 7'b0001110; 16: return 7'b0111111; 17: return 7'b0101011;
            default: return 7'b1111111;
        endcase
    endfunction

    // Model state
    int         t;          // edges since reset released
    logic [6:0] m_dig [ND];
    bit         m_ovf;
    int         m_busy;     // remaining busy cycles
    int         pend;       // value being converted
    int         bk;         // cycles since disp_end went high
    logic [6:0] e_seg;
    logic [ND-1:0] e_en;
    logic       e_busy, e_ovf;

    task automatic model_edge();
        int idx;
        int p10;
        bit on;
        if (reset) begin
            t = 0; m_ovf = 0; m_busy = 0; bk = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = enc_of(0);
            e_seg = 7'b1000000; e_en = 4'b1110; e_busy = 0; e_ovf = 0;
        end else begin
            t++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (pend >= 10000) begin
                        for (int i = 0; i < ND; i++) m_dig[i] = enc_of(16);
                        m_ovf = 1;
                    end else begin
                        p10 = 1;
                        for (int i = 0; i < ND; i++) begin
                            m_dig[i] = enc_of((pend / p10) % 10);
                            p10 = p10 * 10;
                        end
                        m_ovf = 0;
                    end
                end
            end else if (load) begin
                if (mode_sel) begin
                    m_busy = BW;
                    pend = int'(bin_in);
                end else begin
                    for (int i = 0; i < ND; i++) m_dig[i] = enc_of((int'(bin_in) >> (4*i)) & 15);
                    m_ovf = 0;
                end
            end
            on = 1;
            if (disp_end) begin
                on = ((bk / BD) % 2) == 0;
                bk++;
            end else begin
                bk = 0;
            end
            idx = (t / SD) % ND;
            e_en = ~(4'b0001 << idx);
            if (!on) e_seg = 7'b1111111;
            else if (disp_end) e_seg = (idx == 2) ? enc_of(14) : (idx == 1) ? enc_of(17) :
                                       (idx == 0) ? enc_of(13) : enc_of(18);
            else e_seg = m_dig[idx];
            e_busy = (m_busy > 0);
            e_ovf = m_ovf;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        tests++;
        assert (seg_n === e_seg) else begin
            fails++; $error("FAIL seg_n t=%0d observed %b expected %b", t, seg_n, e_seg);
        end
        tests++;
        assert (dig_en_n === e_en) else begin
            fails++; $error("FAIL dig_en_n t=%0d observed %b expected %b", t, dig_en_n, e_en);
        end
        tests++;
        assert (busy === e_busy) else begin
            fails++; $error("FAIL busy t=%0d observed %b expected %b", t, busy, e_busy);
        end
        tests++;
        assert (ovf === e_ovf) else begin
            fails++; $error("FAIL ovf t=%0d observed %b expected %b", t, ovf, e_ovf);
        end
    endtask

    // Step until digit d is enabled (bounded), then compare its segments.
    task automatic check_digit(input int d, input logic [6:0] want, input string tag);
        logic [ND-1:0] en_w;
        bit found;
        en_w = ~(4'b0001 << d);
        found = 0;
        for (int i = 0; i < 2*ND*SD && !found; i++) begin
            step();
            if (dig_en_n === en_w) found = 1;
        end
        tests++;
        assert (found && seg_n === want) else begin
            fails++;
            $error("FAIL %s observed seg_n=%b en=%b expected seg_n=%b en=%b", tag, seg_n, dig_en_n, want, en_w);
        end
    endtask

    task automatic run(input int n, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic do_load(input logic [BW-1:0] v, input logic ms);
        bin_in = v; mode_sel = ms; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic check_busy(input int got, input int want, input string tag);
        tests++;
        assert (got === want) else begin
            fails++; $error("FAIL %s observed %0d busy cycles expected %0d", tag, got, want);
        end
    endtask

    initial begin
        int bc;
        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        run(6, bc);

        // Hex 0x1A2F: no busy, immediate display
        bc = 0;
        do_load(16'h1A2F, 1'b0);
        if (busy === 1'b1) bc++;
        begin int b2; run(8, b2); bc += b2; end
        check_busy(bc, 0, "hex_busy");
        check_digit(0, 7'b0001110, "hex_d0");
        check_digit(1, 7'b0100100, "hex_d1");
        check_digit(2, 7'b0001000, "hex_d2");
        check_digit(3, 7'b1111001, "hex_d3");

        // Decimal 1234: busy exactly 16 cycles, old value held meanwhile
        do_load(16'd1234, 1'b1);
        bc = (busy === 1'b1) ? 1 : 0;
        begin int b2; run(24, b2); bc += b2; end
        check_busy(bc, 16, "dec_busy");
        check_digit(0, 7'b0011001, "dec_d0");
        check_digit(3, 7'b1111001, "dec_d3");

        // Overflow then hex clears ovf
        do_load(16'd10000, 1'b1);
        run(20, bc);
        check_digit(2, 7'b0111111, "ovf_d2");
        do_load(16'h0005, 1'b0);
        check_digit(0, 7'b0010010, "hex5_d0");
        check_digit(3, 7'b1000000, "hex5_d3");

        // Busy collision: second load ignored
        do_load(16'd42, 1'b1);
        do_load(16'hFFFF, 1'b0);
        run(20, bc);
        check_digit(1, 7'b0011001, "coll_d1");
        check_digit(0, 7'b0100100, "coll_d0");

        // End message with blink, then stored value returns
        disp_end = 1'b1;
        run(40, bc);
        disp_end = 1'b0;
        run(16, bc);

        // Reset on the 5th busy cycle of a conversion
        do_load(16'd999, 1'b1);
        run(3, bc);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(20, bc);

        // Reset overrides load on the same edge
        reset = 1'b1; load = 1'b1; mode_sel = 1'b0; bin_in = 16'h1234;
        step();
        reset = 1'b0; load = 1'b0;
        run(4, bc);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 249) == 0);
            load     = ($urandom_range(0, 7) == 0);
            mode_sel = $urandom_range(0, 1) != 0;
            bin_in   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            if ($urandom_range(0, 39) == 0) disp_end = ~disp_end;
            step();
        end
        reset = 1'b0; load = 1'b0; disp_end = 1'b0;
        run(24, bc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
